// File: rtl/led_sequencer_if.sv
// Data-memory write port that carries LED register updates from the sequencer
// to the memory block.
interface led_sequencer_if;
    logic        dmem_wren;
    logic [31:0] dmem_address;
    logic [31:0] dmem_data_in;
    logic [2:0]  funct3;

    modport master (
        output dmem_wren,
        output dmem_address,
        output dmem_data_in,
        output funct3
    );

    modport slave (
        input  dmem_wren,
        input  dmem_address,
        input  dmem_data_in,
        input  funct3
    );
endinterface

// File: rtl/led_sequencer.sv
// Colour-sequence engine: steps through a writable colour table and pushes each
// colour to the LED register with a programmable dwell, in loop/ping-pong/one-shot.
module led_sequencer #(
    parameter int          NUM_STEPS = 6,
    parameter int          DWELL_W   = 22,
    parameter logic [31:0] LED_ADDR  = 32'hFFFF_FFFC,
    localparam int         IDX_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic [1:0]         mode,
    input  logic [DWELL_W-1:0] dwell_cycles,
    input  logic               tbl_wren,
    input  logic [IDX_W-1:0]   tbl_addr,
    input  logic [31:0]        tbl_data,
    led_sequencer_if.master    dmem,
    output logic [IDX_W-1:0]   step_idx,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DWELL,
        S_DONE
    } state_t;

    localparam logic [1:0]       MODE_PINGPONG = 2'd1;
    localparam logic [1:0]       MODE_ONESHOT  = 2'd2;
    localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(NUM_STEPS - 1);
    localparam logic [IDX_W:0]   NUM_STEPS_EXT = (IDX_W + 1)'(NUM_STEPS);

    function automatic logic [31:0] default_color(input int i);
        case (i)
            0:       return 32'hFFFF_0000;
            1:       return 32'hFFFF_FF00;
            2:       return 32'hFF00_FF00;
            3:       return 32'h0000_FFFF;
            4:       return 32'h0000_00FF;
            5:       return 32'h00FF_00FF;
            default: return 32'h0000_0000;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               dir_up_q, dir_up_d;
    logic [1:0]         mode_q, mode_d;
    logic [DWELL_W-1:0] count_q, count_d;
    logic               wren_q, wren_d;
    logic [31:0]        data_q, data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [31:0]        tbl_q [NUM_STEPS];
    logic [31:0]        tbl_d [NUM_STEPS];

    logic [IDX_W-1:0]   next_idx;
    logic               next_dir_up;
    logic               last_step;

    // Table writes land on the same edge that may load a colour into data_q;
    // the load reads tbl_q, so a colliding write is seen on the next visit.
    always_comb begin
        tbl_d = tbl_q;
        if (tbl_wren && ({1'b0, tbl_addr} < NUM_STEPS_EXT)) begin
            tbl_d[tbl_addr] = tbl_data;
        end
    end

    always_comb begin
        next_idx    = idx_q;
        next_dir_up = dir_up_q;
        last_step   = 1'b0;
        case (mode_q)
            MODE_PINGPONG: begin
                if (NUM_STEPS == 1) begin
                    next_idx = '0;
                end else if (dir_up_q) begin
                    if (idx_q == LAST_IDX) begin
                        next_idx    = idx_q - 1'b1;
                        next_dir_up = 1'b0;
                    end else begin
                        next_idx = idx_q + 1'b1;
                    end
                end else begin
                    if (idx_q == '0) begin
                        next_idx    = IDX_W'(1);
                        next_dir_up = 1'b1;
                    end else begin
                        next_idx = idx_q - 1'b1;
                    end
                end
            end
            MODE_ONESHOT: begin
                if (idx_q == LAST_IDX) begin
                    last_step = 1'b1;
                end else begin
                    next_idx = idx_q + 1'b1;
                end
            end
            default: begin
                next_idx = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dir_up_d = dir_up_q;
        mode_d   = mode_q;
        count_d  = count_q;

        if (stop) begin
            state_d = S_IDLE;
        end else if (start) begin
            state_d  = S_WRITE;
            idx_d    = '0;
            dir_up_d = 1'b1;
            mode_d   = mode;
        end else begin
            case (state_q)
                S_WRITE: begin
                    count_d = dwell_cycles;
                    state_d = S_DWELL;
                end
                S_DWELL: begin
                    if (!pause) begin
                        if (count_q != '0) begin
                            count_d = count_q - 1'b1;
                        end else if (last_step) begin
                            state_d = S_DONE;
                        end else begin
                            state_d  = S_WRITE;
                            idx_d    = next_idx;
                            dir_up_d = next_dir_up;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        // Outputs are registered from the next state so they line up with it.
        wren_d = (state_d == S_WRITE);
        data_d = (state_d == S_WRITE) ? tbl_q[idx_d] : data_q;
        busy_d = (state_d == S_WRITE) || (state_d == S_DWELL);
        done_d = (state_d == S_DONE);
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            dir_up_q <= 1'b1;
            mode_q   <= 2'd0;
            count_q  <= '0;
            wren_q   <= 1'b0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < NUM_STEPS; i++) begin
                tbl_q[i] <= default_color(i);
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dir_up_q <= dir_up_d;
            mode_q   <= mode_d;
            count_q  <= count_d;
            wren_q   <= wren_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tbl_q    <= tbl_d;
        end
    end

    assign dmem.dmem_wren    = wren_q;
    assign dmem.dmem_address = LED_ADDR;
    assign dmem.dmem_data_in = data_q;
    assign dmem.funct3       = 3'b010;
    assign step_idx          = idx_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: a six-step instance plus a one-step instance
// that shares its control inputs.
`timescale 1ns/1ps
module tb_led_sequencer;
    localparam int DW = 22;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start, stop, pause;
    logic [1:0]    mode;
    logic [DW-1:0] dwell_cycles;
    logic          tbl_wren;
    logic [2:0]    tbl_addr;
    logic [31:0]   tbl_data;
    logic [2:0]    step_idx;
    logic          busy, done;

    logic [0:0]    s_tbl_addr;
    logic [0:0]    s_step_idx;
    logic          s_busy, s_done;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_colors [6] = '{32'hFFFF0000, 32'hFFFFFF00, 32'hFF00FF00,
                                    32'h0000FFFF, 32'h000000FF, 32'h00FF00FF};

    led_sequencer_if bus ();
    led_sequencer_if s_bus ();

    led_sequencer #(.NUM_STEPS(6), .DWELL_W(DW), .LED_ADDR(32'hFFFFFFFC)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .dwell_cycles(dwell_cycles), .tbl_wren(tbl_wren),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data), .dmem(bus),
        .step_idx(step_idx), .busy(busy), .done(done)
    );

    led_sequencer #(.NUM_STEPS(1), .DWELL_W(DW), .LED_ADDR(32'hFFFFFFFC)) s_dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .dwell_cycles(dwell_cycles), .tbl_wren(1'b0),
        .tbl_addr(s_tbl_addr), .tbl_data(32'h0), .dmem(s_bus),
        .step_idx(s_step_idx), .busy(s_busy), .done(s_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks are entered and left just after a rising edge; the DUT acts on falling edges.
    task automatic wait_write(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(posedge clk);
            n++;
            if (bus.dmem_wren === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(posedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop;
        stop = 1'b1;
        @(posedge clk);
        stop = 1'b0;
    endtask

    task automatic test_reset;
        int n; bit ok;
        repeat (2) @(posedge clk);
        checks++; if (bus.dmem_wren !== 1'b0) begin errors++; $display("FAIL rst_wren: got %b want 0", bus.dmem_wren); end
        checks++; if (bus.dmem_address !== 32'hFFFFFFFC) begin errors++; $display("FAIL rst_addr: got %h want FFFFFFFC", bus.dmem_address); end
        checks++; if (bus.dmem_data_in !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", bus.dmem_data_in); end
        checks++; if (bus.funct3 !== 3'b010) begin errors++; $display("FAIL rst_funct3: got %b want 010", bus.funct3); end
        checks++; if ({step_idx, busy, done} !== 5'b0) begin errors++; $display("FAIL rst_status: got idx=%0d busy=%b done=%b want 0/0/0", step_idx, busy, done); end
        checks++; if ({s_busy, s_done} !== 2'b0) begin errors++; $display("FAIL rst_single: got busy=%b done=%b want 0/0", s_busy, s_done); end
        reset = 1'b1;
        @(posedge clk);
        dwell_cycles = 3; mode = 2'd0;
        pulse_start;
        wait_write(n, ok);
        checks++; if (!ok || step_idx !== 3'd1) begin errors++; $display("FAIL rst_prerun: got ok=%0d idx=%0d want 1/1", ok, step_idx); end
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if ({bus.dmem_wren, busy, step_idx} !== 5'b0) begin errors++; $display("FAIL rst_async: got wren=%b busy=%b idx=%0d want 0/0/0", bus.dmem_wren, busy, step_idx); end
        checks++; if (bus.dmem_data_in !== 32'h0) begin errors++; $display("FAIL rst_async_data: got %h want 0", bus.dmem_data_in); end
        @(posedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        checks++; if (bus.dmem_wren !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_quiet: got wren=%b busy=%b want 0/0", bus.dmem_wren, busy); end
        $display("reset: defaults and async abort checked");
    endtask

    task automatic test_loop;
        int n; bit ok;
        dwell_cycles = 3; mode = 2'd0;
        pulse_start;
        checks++; if (bus.dmem_wren !== 1'b1 || step_idx !== 3'd0 || busy !== 1'b1) begin errors++; $display("FAIL loop_first: got wren=%b idx=%0d busy=%b want 1/0/1", bus.dmem_wren, step_idx, busy); end
        checks++; if (bus.dmem_data_in !== exp_colors[0] || bus.dmem_address !== 32'hFFFFFFFC || bus.funct3 !== 3'b010) begin errors++; $display("FAIL loop_first_bus: got data=%h addr=%h f3=%b want %h/FFFFFFFC/010", bus.dmem_data_in, bus.dmem_address, bus.funct3, exp_colors[0]); end
        for (int i = 1; i <= 6; i++) begin
            wait_write(n, ok);
            checks++; if (!ok || n != 5) begin errors++; $display("FAIL loop_gap[%0d]: got ok=%0d gap=%0d want 5", i, ok, n); end
            checks++; if (bus.dmem_data_in !== exp_colors[i % 6] || step_idx !== 3'(i % 6)) begin errors++; $display("FAIL loop_data[%0d]: got idx=%0d data=%h want idx=%0d data=%h", i, step_idx, bus.dmem_data_in, i % 6, exp_colors[i % 6]); end
            $display("loop write %0d: idx=%0d data=%h gap=%0d", i, step_idx, bus.dmem_data_in, n);
        end
        @(posedge clk);
        pulse_start;
        checks++; if (bus.dmem_wren !== 1'b1 || step_idx !== 3'd0 || bus.dmem_data_in !== exp_colors[0]) begin errors++; $display("FAIL restart: got wren=%b idx=%0d data=%h want 1/0/%h", bus.dmem_wren, step_idx, bus.dmem_data_in, exp_colors[0]); end
        pulse_stop;
        checks++; if ({bus.dmem_wren, busy, done} !== 3'b0) begin errors++; $display("FAIL loop_stop: got wren=%b busy=%b done=%b want 0/0/0", bus.dmem_wren, busy, done); end
    endtask

    task automatic test_pingpong;
        int n; bit ok;
        logic [2:0] seq [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
        dwell_cycles = 0; mode = 2'd1;
        pulse_start;
        checks++; if (step_idx !== 3'd0 || s_bus.dmem_wren !== 1'b1 || s_step_idx !== 1'b0) begin errors++; $display("FAIL pp_first: got idx=%0d s_wren=%b s_idx=%0d want 0/1/0", step_idx, s_bus.dmem_wren, s_step_idx); end
        for (int i = 1; i < 12; i++) begin
            wait_write(n, ok);
            checks++; if (!ok || n != 2 || step_idx !== seq[i] || bus.dmem_data_in !== exp_colors[seq[i]]) begin errors++; $display("FAIL pp[%0d]: got ok=%0d gap=%0d idx=%0d data=%h want gap=2 idx=%0d", i, ok, n, step_idx, bus.dmem_data_in, seq[i]); end
            checks++; if (s_bus.dmem_wren !== 1'b1 || s_step_idx !== 1'b0 || s_bus.dmem_data_in !== 32'hFFFF0000) begin errors++; $display("FAIL pp_single[%0d]: got wren=%b idx=%0d data=%h want 1/0/FFFF0000", i, s_bus.dmem_wren, s_step_idx, s_bus.dmem_data_in); end
            $display("pingpong write %0d: idx=%0d single_idx=%0d", i, step_idx, s_step_idx);
        end
        pulse_stop;
    endtask

    task automatic test_oneshot;
        int n; bit ok; bit stray;
        dwell_cycles = 2; mode = 2'd2;
        pulse_start;
        checks++; if (step_idx !== 3'd0 || bus.dmem_wren !== 1'b1) begin errors++; $display("FAIL os_first: got idx=%0d wren=%b want 0/1", step_idx, bus.dmem_wren); end
        for (int i = 1; i < 6; i++) begin
            wait_write(n, ok);
            checks++; if (!ok || n != 4 || step_idx !== 3'(i)) begin errors++; $display("FAIL os[%0d]: got ok=%0d gap=%0d idx=%0d want gap=4 idx=%0d", i, ok, n, step_idx, i); end
            $display("oneshot write %0d: idx=%0d data=%h", i, step_idx, bus.dmem_data_in);
        end
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            if (c < 4) begin
                checks++; if ({bus.dmem_wren, busy, done} !== 3'b010) begin errors++; $display("FAIL os_dwell[%0d]: got wren=%b busy=%b done=%b want 0/1/0", c, bus.dmem_wren, busy, done); end
            end else begin
                checks++; if ({bus.dmem_wren, busy, done} !== 3'b001) begin errors++; $display("FAIL os_done: got wren=%b busy=%b done=%b want 0/0/1", bus.dmem_wren, busy, done); end
            end
        end
        stray = 1'b0;
        repeat (8) begin
            @(posedge clk);
            if (bus.dmem_wren !== 1'b0) stray = 1'b1;
        end
        checks++; if (stray) begin errors++; $display("FAIL os_no_more: got wren pulse after DONE want none"); end
        checks++; if (step_idx !== 3'd5 || bus.dmem_data_in !== 32'h00FF00FF || done !== 1'b1) begin errors++; $display("FAIL os_hold: got idx=%0d data=%h done=%b want 5/00FF00FF/1", step_idx, bus.dmem_data_in, done); end
        pulse_start;
        checks++; if (bus.dmem_wren !== 1'b1 || step_idx !== 3'd0 || done !== 1'b0 || bus.dmem_data_in !== exp_colors[0]) begin errors++; $display("FAIL os_restart: got wren=%b idx=%0d done=%b data=%h want 1/0/0/%h", bus.dmem_wren, step_idx, done, bus.dmem_data_in, exp_colors[0]); end
        $display("oneshot restart: idx=%0d", step_idx);
        pulse_stop;
    endtask

    task automatic test_pause;
        int n; bit ok; bit stray;
        dwell_cycles = 4; mode = 2'd0;
        pulse_start;
        repeat (2) @(posedge clk);
        pause = 1'b1;
        repeat (3) @(posedge clk);
        pause = 1'b0;
        wait_write(n, ok);
        checks++; if (!ok || (n + 5) != 9 || step_idx !== 3'd1) begin errors++; $display("FAIL pause_gap: got ok=%0d gap=%0d idx=%0d want 9/1", ok, n + 5, step_idx); end
        $display("pause write: gap=%0d idx=%0d", n + 5, step_idx);
        @(posedge clk);
        pulse_stop;
        checks++; if ({bus.dmem_wren, busy, done} !== 3'b0 || step_idx !== 3'd1) begin errors++; $display("FAIL stop_dwell: got wren=%b busy=%b done=%b idx=%0d want 0/0/0/1", bus.dmem_wren, busy, done, step_idx); end
        stray = 1'b0;
        repeat (10) begin
            @(posedge clk);
            if (bus.dmem_wren !== 1'b0) stray = 1'b1;
        end
        checks++; if (stray) begin errors++; $display("FAIL stop_quiet: got wren pulse after stop want none"); end
        start = 1'b1; stop = 1'b1;
        @(posedge clk);
        start = 1'b0; stop = 1'b0;
        checks++; if (bus.dmem_wren !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL start_stop: got wren=%b busy=%b want 0/0", bus.dmem_wren, busy); end
        repeat (3) @(posedge clk);
        checks++; if (busy !== 1'b0 || step_idx !== 3'd1) begin errors++; $display("FAIL start_stop_idle: got busy=%b idx=%0d want 0/1", busy, step_idx); end
        $display("start+stop: busy=%b", busy);
    endtask

    task automatic test_table;
        int n; bit ok;
        logic [31:0] exp_rest [6] = '{32'h000000FF, 32'h00FF00FF, 32'hFFFF0000,
                                      32'hFFFFFF00, 32'h12345678, 32'hAAAA5555};
        dwell_cycles = 3; mode = 2'd0;
        pulse_start;
        wait_write(n, ok);
        tbl_wren = 1'b1; tbl_addr = 3'd2; tbl_data = 32'h12345678;
        @(posedge clk);
        tbl_wren = 1'b0;
        wait_write(n, ok);
        checks++; if (!ok || n != 4 || step_idx !== 3'd2 || bus.dmem_data_in !== 32'h12345678) begin errors++; $display("FAIL tbl_new: got ok=%0d gap=%0d idx=%0d data=%h want 4/2/12345678", ok, n, step_idx, bus.dmem_data_in); end
        $display("table write idx2: data=%h", bus.dmem_data_in);
        wait_write(n, ok);
        checks++; if (!ok || step_idx !== 3'd3 || bus.dmem_data_in !== 32'h0000FFFF) begin errors++; $display("FAIL tbl_idx3: got idx=%0d data=%h want 3/0000FFFF", step_idx, bus.dmem_data_in); end
        tbl_wren = 1'b1; tbl_addr = 3'd3; tbl_data = 32'hAAAA5555;
        @(posedge clk);
        checks++; if (bus.dmem_data_in !== 32'h0000FFFF) begin errors++; $display("FAIL tbl_collide: got %h want 0000FFFF", bus.dmem_data_in); end
        tbl_addr = 3'd7; tbl_data = 32'hDEADBEEF;
        @(posedge clk);
        tbl_wren = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wait_write(n, ok);
            checks++; if (!ok || n != ((i == 0) ? 3 : 5) || bus.dmem_data_in !== exp_rest[i]) begin errors++; $display("FAIL tbl_pass[%0d]: got ok=%0d gap=%0d data=%h want %h", i, ok, n, bus.dmem_data_in, exp_rest[i]); end
            $display("table pass write %0d: idx=%0d data=%h", i, step_idx, bus.dmem_data_in);
        end
        pulse_stop;
    endtask

    initial begin
        start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 2'd0; dwell_cycles = '0;
        tbl_wren = 1'b0; tbl_addr = '0; tbl_data = '0; s_tbl_addr = '0;
        test_reset;
        test_loop;
        test_pingpong;
        test_oneshot;
        test_pause;
        test_table;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
